// File: rtl/lcd_spi_rx.sv
// Receive side of the 4-wire LCD SPI bus: deserialises bytes, classifies them as
// command/parameter, tracks the CASET/RASET address window and emits RGB565 pixels.
module lcd_spi_rx #(
  parameter int X_W    = 9,
  parameter int DEF_XE = 239,
  parameter int DEF_YE = 319
) (
  input  logic           clk,
  input  logic           resetn,
  input  logic           sclk,
  input  logic           cs_n,
  input  logic           dc,
  input  logic           sdi,
  output logic           cmd_valid,
  output logic           param_valid,
  output logic [7:0]     byte_out,
  output logic           pix_valid,
  output logic [15:0]    pix_data,
  output logic [X_W-1:0] pix_x,
  output logic [X_W-1:0] pix_y,
  output logic           frame_done
);

  localparam logic [X_W-1:0] XE_RST = X_W'(DEF_XE);
  localparam logic [X_W-1:0] YE_RST = X_W'(DEF_YE);

  typedef enum logic [2:0] {ST_IDLE, ST_CASET, ST_RASET, ST_RAMWR, ST_OTHER} state_t;

  logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_prev_q, sclk_prev_d;
  logic cs_meta_q, cs_meta_d, cs_sync_q, cs_sync_d;
  logic dc_meta_q, dc_meta_d, dc_sync_q, dc_sync_d;
  logic sdi_meta_q, sdi_meta_d, sdi_sync_q, sdi_sync_d;

  logic [2:0]     bit_cnt_q, bit_cnt_d;
  logic [6:0]     sr_q, sr_d;
  logic           byte_stb_q, byte_stb_d;
  logic [7:0]     byte_q, byte_d;
  logic           byte_dc_q, byte_dc_d;

  state_t         state_q, state_d;
  logic [1:0]     pcnt_q, pcnt_d;
  logic [7:0]     p0_q, p0_d, p1_q, p1_d, p2_q, p2_d;
  logic [X_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
  logic [X_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
  logic           phase_q, phase_d;
  logic [7:0]     hi_q, hi_d;

  logic           cmd_valid_q, cmd_valid_d, param_valid_q, param_valid_d;
  logic [7:0]     byte_out_q, byte_out_d;
  logic           pix_valid_q, pix_valid_d, frame_done_q, frame_done_d;
  logic [15:0]    pix_data_q, pix_data_d;
  logic [X_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;

  logic           sclk_rise;
  logic [X_W-1:0] win_start, win_end;

  assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
  // Window coordinates keep only the low X_W bits of the 16-bit parameters.
  assign win_start = X_W'({p0_q, p1_q});
  assign win_end   = X_W'({p2_q, byte_q});

  always_comb begin
    sclk_meta_d = sclk;   sclk_sync_d = sclk_meta_q;  sclk_prev_d = sclk_sync_q;
    cs_meta_d   = cs_n;   cs_sync_d   = cs_meta_q;
    dc_meta_d   = dc;     dc_sync_d   = dc_meta_q;
    sdi_meta_d  = sdi;    sdi_sync_d  = sdi_meta_q;

    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    byte_stb_d = 1'b0;
    byte_d     = byte_q;
    byte_dc_d  = byte_dc_q;
    if (cs_sync_q) begin
      bit_cnt_d = '0;
    end else if (sclk_rise) begin
      sr_d      = {sr_q[5:0], sdi_sync_q};
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        byte_stb_d = 1'b1;
        byte_d     = {sr_q, sdi_sync_q};
        byte_dc_d  = dc_sync_q;
      end
    end

    state_d = state_q;  pcnt_d = pcnt_q;
    p0_d = p0_q;  p1_d = p1_q;  p2_d = p2_q;
    xs_d = xs_q;  xe_d = xe_q;  ys_d = ys_q;  ye_d = ye_q;
    cur_x_d = cur_x_q;  cur_y_d = cur_y_q;
    phase_d = phase_q;  hi_d = hi_q;
    cmd_valid_d = 1'b0;  param_valid_d = 1'b0;  pix_valid_d = 1'b0;  frame_done_d = 1'b0;
    byte_out_d = byte_out_q;  pix_data_d = pix_data_q;
    pix_x_d = pix_x_q;  pix_y_d = pix_y_q;

    if (byte_stb_q) begin
      if (!byte_dc_q) begin
        // Any command aborts partial parameters and an odd pixel byte.
        cmd_valid_d = 1'b1;
        byte_out_d  = byte_q;
        pcnt_d      = '0;
        phase_d     = 1'b0;
        case (byte_q)
          8'h2A:   state_d = ST_CASET;
          8'h2B:   state_d = ST_RASET;
          8'h2C: begin
            state_d = ST_RAMWR;
            cur_x_d = xs_q;
            cur_y_d = ys_q;
          end
          default: state_d = ST_OTHER;
        endcase
      end else begin
        case (state_q)
          ST_CASET, ST_RASET: begin
            param_valid_d = 1'b1;
            byte_out_d    = byte_q;
            pcnt_d        = pcnt_q + 2'd1;
            case (pcnt_q)
              2'd0: p0_d = byte_q;
              2'd1: p1_d = byte_q;
              2'd2: p2_d = byte_q;
              default: begin
                if (state_q == ST_CASET) begin
                  xs_d = win_start;
                  xe_d = win_end;
                end else begin
                  ys_d = win_start;
                  ye_d = win_end;
                end
                state_d = ST_OTHER;
              end
            endcase
          end
          ST_RAMWR: begin
            if (!phase_q) begin
              hi_d    = byte_q;
              phase_d = 1'b1;
            end else begin
              phase_d     = 1'b0;
              pix_valid_d = 1'b1;
              pix_data_d  = {hi_q, byte_q};
              pix_x_d     = cur_x_q;
              pix_y_d     = cur_y_q;
              cur_x_d     = (cur_x_q == xe_q) ? xs_q : cur_x_q + X_W'(1);
              if (cur_x_q == xe_q) begin
                if (cur_y_q == ye_q) begin
                  cur_y_d      = ys_q;
                  frame_done_d = 1'b1;
                end else begin
                  cur_y_d = cur_y_q + X_W'(1);
                end
              end
            end
          end
          default: begin
            param_valid_d = 1'b1;
            byte_out_d    = byte_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk_meta_q <= 1'b0;  sclk_sync_q <= 1'b0;  sclk_prev_q <= 1'b0;
      cs_meta_q   <= 1'b1;  cs_sync_q   <= 1'b1;
      dc_meta_q   <= 1'b1;  dc_sync_q   <= 1'b1;
      sdi_meta_q  <= 1'b1;  sdi_sync_q  <= 1'b1;
      bit_cnt_q   <= '0;    sr_q        <= '0;
      byte_stb_q  <= 1'b0;  byte_q      <= '0;    byte_dc_q <= 1'b0;
      state_q     <= ST_IDLE;
      pcnt_q      <= '0;
      p0_q <= '0;  p1_q <= '0;  p2_q <= '0;
      xs_q <= '0;  xe_q <= XE_RST;  ys_q <= '0;  ye_q <= YE_RST;
      cur_x_q <= '0;  cur_y_q <= '0;
      phase_q <= 1'b0;  hi_q <= '0;
      cmd_valid_q <= 1'b0;  param_valid_q <= 1'b0;  pix_valid_q <= 1'b0;  frame_done_q <= 1'b0;
      byte_out_q <= '0;  pix_data_q <= '0;  pix_x_q <= '0;  pix_y_q <= '0;
    end else begin
      sclk_meta_q <= sclk_meta_d;  sclk_sync_q <= sclk_sync_d;  sclk_prev_q <= sclk_prev_d;
      cs_meta_q   <= cs_meta_d;    cs_sync_q   <= cs_sync_d;
      dc_meta_q   <= dc_meta_d;    dc_sync_q   <= dc_sync_d;
      sdi_meta_q  <= sdi_meta_d;   sdi_sync_q  <= sdi_sync_d;
      bit_cnt_q   <= bit_cnt_d;    sr_q        <= sr_d;
      byte_stb_q  <= byte_stb_d;   byte_q      <= byte_d;   byte_dc_q <= byte_dc_d;
      state_q     <= state_d;
      pcnt_q      <= pcnt_d;
      p0_q <= p0_d;  p1_q <= p1_d;  p2_q <= p2_d;
      xs_q <= xs_d;  xe_q <= xe_d;  ys_q <= ys_d;  ye_q <= ye_d;
      cur_x_q <= cur_x_d;  cur_y_q <= cur_y_d;
      phase_q <= phase_d;  hi_q <= hi_d;
      cmd_valid_q <= cmd_valid_d;  param_valid_q <= param_valid_d;
      pix_valid_q <= pix_valid_d;  frame_done_q <= frame_done_d;
      byte_out_q <= byte_out_d;  pix_data_q <= pix_data_d;
      pix_x_q <= pix_x_d;  pix_y_q <= pix_y_d;
    end
  end

  assign cmd_valid   = cmd_valid_q;
  assign param_valid = param_valid_q;
  assign byte_out    = byte_out_q;
  assign pix_valid   = pix_valid_q;
  assign pix_data    = pix_data_q;
  assign pix_x       = pix_x_q;
  assign pix_y       = pix_y_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// Bench for lcd_spi_rx: directed scenarios with constant expectations plus a
// randomized run checked against a byte-level model of the display protocol.
module tb_lcd_spi_rx;
  localparam int X_W  = 9;
  localparam int MODV = 1 << X_W;

  logic clk = 1'b0, resetn = 1'b0, sclk = 1'b0, cs_n = 1'b1, dc = 1'b1, sdi = 1'b1;
  logic cmd_valid, param_valid, pix_valid, frame_done;
  logic [7:0] byte_out;
  logic [15:0] pix_data;
  logic [X_W-1:0] pix_x, pix_y;

  always #5 clk = ~clk;

  lcd_spi_rx #(.X_W(X_W), .DEF_XE(239), .DEF_YE(319)) dut (
    .clk(clk), .resetn(resetn), .sclk(sclk), .cs_n(cs_n), .dc(dc), .sdi(sdi),
    .cmd_valid(cmd_valid), .param_valid(param_valid), .byte_out(byte_out),
    .pix_valid(pix_valid), .pix_data(pix_data), .pix_x(pix_x), .pix_y(pix_y),
    .frame_done(frame_done)
  );

  // kind: 0 command, 1 parameter, 2 pixel, 3 stray frame_done
  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
    logic [8:0]  x;
    logic [8:0]  y;
    logic        fd;
  } ev_t;

  ev_t obs[$];
  ev_t m_exp[$];
  int errors = 0, checks = 0, multi_cnt = 0;

  function automatic ev_t mk(input int k, input int v, input int x, input int y, input int fd);
    ev_t e;
    e.kind = 2'(k); e.val = 16'(v); e.x = 9'(x); e.y = 9'(y); e.fd = (fd != 0);
    return e;
  endfunction

  always @(negedge clk) begin
    if (resetn) begin
      if (int'(cmd_valid) + int'(param_valid) + int'(pix_valid) > 1) multi_cnt++;
      if (cmd_valid)   obs.push_back(mk(0, int'(byte_out), 0, 0, 0));
      if (param_valid) obs.push_back(mk(1, int'(byte_out), 0, 0, 0));
      if (pix_valid)   obs.push_back(mk(2, int'(pix_data), int'(pix_x), int'(pix_y), int'(frame_done)));
      if (frame_done && !pix_valid) obs.push_back(mk(3, 0, 0, 0, 1));
    end
  end

  // Protocol model: window registers, cursor and pixel pairing in plain integers.
  int m_xs, m_xe, m_ys, m_ye, m_cx, m_cy, m_mode, m_pc, m_phase, m_hi;
  int m_p[4];

  task automatic model_reset();
    m_xs = 0; m_xe = 239; m_ys = 0; m_ye = 319; m_cx = 0; m_cy = 0;
    m_mode = 0; m_pc = 0; m_phase = 0; m_hi = 0;
  endtask

  task automatic model_byte(input int b, input int d);
    int s, e, fd;
    if (d == 0) begin
      m_exp.push_back(mk(0, b, 0, 0, 0));
      m_pc = 0; m_phase = 0;
      m_mode = (b == 'h2A) ? 1 : (b == 'h2B) ? 2 : (b == 'h2C) ? 3 : 0;
      if (b == 'h2C) begin m_cx = m_xs; m_cy = m_ys; end
    end else if (m_mode == 1 || m_mode == 2) begin
      m_exp.push_back(mk(1, b, 0, 0, 0));
      m_p[m_pc] = b;
      m_pc++;
      if (m_pc == 4) begin
        s = (m_p[0] * 256 + m_p[1]) % MODV;
        e = (m_p[2] * 256 + m_p[3]) % MODV;
        if (m_mode == 1) begin m_xs = s; m_xe = e; end else begin m_ys = s; m_ye = e; end
        m_mode = 0; m_pc = 0;
      end
    end else if (m_mode == 3) begin
      if (m_phase == 0) begin
        m_hi = b; m_phase = 1;
      end else begin
        fd = 0;
        if (m_cx == m_xe) begin
          fd = (m_cy == m_ye) ? 1 : 0;
          m_exp.push_back(mk(2, m_hi * 256 + b, m_cx, m_cy, fd));
          m_cx = m_xs;
          m_cy = fd ? m_ys : (m_cy + 1) % MODV;
        end else begin
          m_exp.push_back(mk(2, m_hi * 256 + b, m_cx, m_cy, 0));
          m_cx = (m_cx + 1) % MODV;
        end
        m_phase = 0;
      end
    end else begin
      m_exp.push_back(mk(1, b, 0, 0, 0));
    end
  endtask

  task automatic spi_bits(input logic [7:0] b, input logic d, input int nbits);
    dc = d;
    for (int i = 0; i < nbits; i++) begin
      sdi = b[7-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic d);
    spi_bits(b, d, 8);
    model_byte(int'(b), int'(d));
    $display("spi byte %02h dc=%0d", b, d);
  endtask

  task automatic cs_low();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; cs_n = 1'b1; sclk = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    model_reset();
    obs.delete();
    m_exp.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if ({cmd_valid, param_valid, pix_valid, frame_done} !== 4'b0) begin errors++; $display("FAIL reset_pulses: got %b required 0000", {cmd_valid, param_valid, pix_valid, frame_done}); end
    checks++; if (byte_out !== 8'h00) begin errors++; $display("FAIL reset_byte_out: got %h required 00", byte_out); end
    checks++; if (pix_data !== 16'h0000) begin errors++; $display("FAIL reset_pix_data: got %h required 0000", pix_data); end
    checks++; if ({pix_x, pix_y} !== '0) begin errors++; $display("FAIL reset_pix_xy: got (%0d,%0d) required (0,0)", pix_x, pix_y); end
    resetn = 1'b1;
    obs.delete();
    for (int i = 0; i < 25; i++) begin
      sclk = ~sclk; sdi = 1'($urandom); dc = 1'($urandom);
      repeat (4) @(negedge clk);
    end
    sclk = 1'b0;
    repeat (8) @(negedge clk);
    checks++; if (obs.size() != 0) begin errors++; $display("FAIL idle_events: got %0d pulses required 0", obs.size()); end
    checks++; if ({byte_out, pix_data, pix_x, pix_y} !== '0) begin errors++; $display("FAIL idle_outputs: got byte=%h pix=%h x=%0d y=%0d required all 0", byte_out, pix_data, pix_x, pix_y); end
  endtask

  task automatic test_latency();
    do_reset();
    cs_low();
    spi_bits(8'h01, 1'b0, 7);
    sdi = 1'b1;
    repeat (4) @(negedge clk);
    sclk = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_early: got cmd_valid=%b required 0", cmd_valid); end
    @(negedge clk);
    checks++; if ({cmd_valid, byte_out} !== {1'b1, 8'h01}) begin errors++; $display("FAIL latency_pulse: got cmd_valid=%b byte=%h required 1 01", cmd_valid, byte_out); end
    @(negedge clk);
    checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL latency_width: got cmd_valid=%b required 0", cmd_valid); end
    sclk = 1'b0;
    cs_high();
  endtask

  task automatic test_window_pixels();
    logic [7:0] cfg [11];
    ev_t want[$];
    do_reset();
    cfg = '{8'h2A, 8'h00, 8'h28, 8'h01, 8'h17, 8'h2B, 8'h00, 8'h35, 8'h00, 8'hBB, 8'h2C};
    cs_low();
    for (int i = 0; i < 11; i++) begin
      send_byte(cfg[i], !(i == 0 || i == 5 || i == 10));
      want.push_back(mk((i == 0 || i == 5 || i == 10) ? 0 : 1, int'(cfg[i]), 0, 0, 0));
    end
    send_byte(8'hF8, 1'b1); send_byte(8'h00, 1'b1); send_byte(8'h07, 1'b1); send_byte(8'hE0, 1'b1);
    want.push_back(mk(2, 'hF800, 40, 53, 0));
    want.push_back(mk(2, 'h07E0, 41, 53, 0));
    cs_high();
    checks++; if (obs.size() != want.size()) begin errors++; $display("FAIL window_count: got %0d events required %0d", obs.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== want[i]) begin errors++; $display("FAIL window_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d fd=%0d required kind=%0d val=%h x=%0d y=%0d fd=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, obs[i].fd, want[i].kind, want[i].val, want[i].x, want[i].y, want[i].fd); end
    end
  endtask

  task automatic test_frame_wrap();
    logic [7:0] cfg [11];
    logic [15:0] v;
    ev_t want[$];
    do_reset();
    cfg = '{8'h2A, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2B, 8'h00, 8'h00, 8'h00, 8'h01, 8'h2C};
    cs_low();
    for (int i = 0; i < 11; i++) begin
      send_byte(cfg[i], !(i == 0 || i == 5 || i == 10));
      want.push_back(mk((i == 0 || i == 5 || i == 10) ? 0 : 1, int'(cfg[i]), 0, 0, 0));
    end
    for (int i = 0; i < 5; i++) begin
      v = 16'($urandom);
      send_byte(v[15:8], 1'b1);
      send_byte(v[7:0], 1'b1);
      want.push_back(mk(2, int'(v), i % 2, (i / 2) % 2, (i == 3) ? 1 : 0));
    end
    cs_high();
    checks++; if (obs.size() != want.size()) begin errors++; $display("FAIL frame_count: got %0d events required %0d", obs.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== want[i]) begin errors++; $display("FAIL frame_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d fd=%0d required kind=%0d val=%h x=%0d y=%0d fd=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, obs[i].fd, want[i].kind, want[i].val, want[i].x, want[i].y, want[i].fd); end
    end
  endtask

  task automatic test_cs_abort();
    ev_t want[$];
    do_reset();
    cs_low();
    spi_bits(8'h2A, 1'b0, 5);
    cs_high();
    cs_low();
    send_byte(8'h2C, 1'b0); send_byte(8'hAB, 1'b1); send_byte(8'hCD, 1'b1);
    cs_high();
    want.push_back(mk(0, 'h2C, 0, 0, 0));
    want.push_back(mk(2, 'hABCD, 0, 0, 0));
    checks++; if (obs.size() != want.size()) begin errors++; $display("FAIL abort_count: got %0d events required %0d", obs.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== want[i]) begin errors++; $display("FAIL abort_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d required kind=%0d val=%h x=%0d y=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, want[i].kind, want[i].val, want[i].x, want[i].y); end
    end
  endtask

  task automatic test_partial_caset();
    ev_t want[$];
    do_reset();
    cs_low();
    send_byte(8'h2A, 1'b0); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    send_byte(8'h2C, 1'b0); send_byte(8'h55, 1'b1); send_byte(8'hAA, 1'b1);
    send_byte(8'h77, 1'b1); send_byte(8'h00, 1'b0);
    send_byte(8'h2C, 1'b0); send_byte(8'h99, 1'b1);
    cs_high();
    cs_low();
    send_byte(8'h88, 1'b1);
    cs_high();
    want.push_back(mk(0, 'h2A, 0, 0, 0)); want.push_back(mk(1, 'h12, 0, 0, 0));
    want.push_back(mk(1, 'h34, 0, 0, 0)); want.push_back(mk(0, 'h2C, 0, 0, 0));
    want.push_back(mk(2, 'h55AA, 0, 0, 0)); want.push_back(mk(0, 'h00, 0, 0, 0));
    want.push_back(mk(0, 'h2C, 0, 0, 0)); want.push_back(mk(2, 'h9988, 0, 0, 0));
    checks++; if (obs.size() != want.size()) begin errors++; $display("FAIL partial_count: got %0d events required %0d", obs.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== want[i]) begin errors++; $display("FAIL partial_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d required kind=%0d val=%h x=%0d y=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, want[i].kind, want[i].val, want[i].x, want[i].y); end
    end
  endtask

  task automatic test_reset_midpixel();
    ev_t want[$];
    do_reset();
    cs_low();
    send_byte(8'h2C, 1'b0); send_byte(8'h56, 1'b1);
    spi_bits(8'h78, 1'b1, 4);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    send_byte(8'h2C, 1'b0); send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
    cs_high();
    want.push_back(mk(0, 'h2C, 0, 0, 0));
    want.push_back(mk(0, 'h2C, 0, 0, 0));
    want.push_back(mk(2, 'h1234, 0, 0, 0));
    checks++; if (obs.size() != want.size()) begin errors++; $display("FAIL midreset_count: got %0d events required %0d", obs.size(), want.size()); end
    for (int i = 0; i < want.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== want[i]) begin errors++; $display("FAIL midreset_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d required kind=%0d val=%h x=%0d y=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, want[i].kind, want[i].val, want[i].x, want[i].y); end
    end
  endtask

  task automatic test_random();
    do_reset();
    cs_low();
    for (int it = 0; it < 8; it++) begin
      int xs0, xe0, ys0, ye0, np;
      xs0 = $urandom_range(0, 500); xe0 = xs0 + $urandom_range(0, 3);
      ys0 = $urandom_range(0, 500); ye0 = ys0 + $urandom_range(0, 3);
      send_byte(8'h2A, 1'b0);
      send_byte(8'(xs0 >> 8) | (8'($urandom) & 8'hFE), 1'b1); send_byte(8'(xs0), 1'b1);
      send_byte(8'(xe0 >> 8) | (8'($urandom) & 8'hFE), 1'b1); send_byte(8'(xe0), 1'b1);
      send_byte(8'h2B, 1'b0);
      send_byte(8'(ys0 >> 8), 1'b1); send_byte(8'(ys0), 1'b1);
      if ($urandom_range(0, 3) != 0) begin
        send_byte(8'(ye0 >> 8), 1'b1); send_byte(8'(ye0), 1'b1);
      end
      if ($urandom_range(0, 2) == 0) begin
        send_byte(8'($urandom), 1'b0); send_byte(8'($urandom), 1'b1);
      end
      send_byte(8'h2C, 1'b0);
      np = $urandom_range(1, 12);
      for (int p = 0; p < 2 * np; p++) begin
        if ($urandom_range(0, 4) == 0) begin cs_high(); cs_low(); end
        send_byte(8'($urandom), 1'b1);
      end
      if ($urandom_range(0, 2) == 0) send_byte(8'($urandom), 1'b1);
    end
    cs_high();
    checks++; if (obs.size() != m_exp.size()) begin errors++; $display("FAIL random_count: got %0d events required %0d", obs.size(), m_exp.size()); end
    for (int i = 0; i < m_exp.size() && i < obs.size(); i++) begin
      checks++;
      if (obs[i] !== m_exp[i]) begin errors++; $display("FAIL random_ev[%0d]: got kind=%0d val=%h x=%0d y=%0d fd=%0d required kind=%0d val=%h x=%0d y=%0d fd=%0d", i, obs[i].kind, obs[i].val, obs[i].x, obs[i].y, obs[i].fd, m_exp[i].kind, m_exp[i].val, m_exp[i].x, m_exp[i].y, m_exp[i].fd); end
    end
  endtask

  task automatic test_one_hot();
    checks++;
    if (multi_cnt !== 0) begin errors++; $display("FAIL one_hot: got %0d cycles with several pulses required 0", multi_cnt); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_latency();
    test_window_pixels();
    test_frame_wrap();
    test_cs_abort();
    test_partial_caset();
    test_reset_midpixel();
    test_random();
    test_one_hot();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
